// File: rtl/esc_update_sequencer_pkg.sv
// Shared widths, speed type and sequencer state encoding for the ESC update sequencer.
package esc_pkg;

    localparam int SPEED_W    = 11;
    localparam int NUM_MOTORS = 4;

    typedef logic [SPEED_W-1:0] speed_t;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        RUN      = 2'd2
    } esc_state_t;

endpackage

// File: rtl/esc_update_sequencer_if.sv
// Flight-controller side request bus and shared ESC write bus of the sequencer.
interface esc_update_sequencer_if;
    import esc_pkg::*;

    logic                  upd;
    speed_t                frnt_spd;
    speed_t                bck_spd;
    speed_t                lft_spd;
    speed_t                rght_spd;
    logic                  arm_req;
    logic                  kill;
    speed_t                SPEED;
    logic [NUM_MOTORS-1:0] wrt;
    logic                  armed;
    logic                  busy;

    modport master (
        output upd, frnt_spd, bck_spd, lft_spd, rght_spd, arm_req, kill,
        input  SPEED, wrt, armed, busy
    );

    modport slave (
        input  upd, frnt_spd, bck_spd, lft_spd, rght_spd, arm_req, kill,
        output SPEED, wrt, armed, busy
    );

endinterface

// File: rtl/esc_update_sequencer_slew.sv
// One motor's slew step: move cur toward tgt by at most MAX_STEP per frame.
module esc_slew_step
    import esc_pkg::*;
#(
    parameter int MAX_STEP = 64
) (
    input  speed_t i_cur,
    input  speed_t i_tgt,
    output speed_t o_nxt
);

    localparam logic signed [SPEED_W:0] STEP_S = (SPEED_W+1)'(MAX_STEP);
    localparam speed_t                  STEP_U = SPEED_W'(MAX_STEP);

    logic signed [SPEED_W:0] w_diff;

    // Signed 12-bit difference; the clamped step never leaves 0..2047 because it stops short of tgt.
    always_comb begin
        w_diff = $signed({1'b0, i_tgt}) - $signed({1'b0, i_cur});
        if (w_diff > STEP_S) begin
            o_nxt = i_cur + STEP_U;
        end else if (w_diff < -STEP_S) begin
            o_nxt = i_cur - STEP_U;
        end else begin
            o_nxt = i_tgt;
        end
    end

endmodule

// File: rtl/esc_update_sequencer.sv
// Frame-rate ESC scheduler: latches targets, arms, slews, and writes four ESCs over a shared bus.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DISARMED | speeds forced to 0, zero frames still written
// ARMING   | zero frames written, counting ARM_FRAMES ticks
// RUN      | speeds slew toward targets once per frame
module esc_update_sequencer
    import esc_pkg::*;
#(
    parameter int FRAME_CYCLES = 50000,
    parameter int ARM_FRAMES   = 1000,
    parameter int MAX_STEP     = 64
) (
    input logic                    clk,
    input logic                    rst,
    esc_update_sequencer_if.slave  bus
);

    localparam int FRM_W = $clog2(FRAME_CYCLES);
    localparam int ARM_W = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FRAME_CYCLES - 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_FRAMES - 1);

    esc_state_t             r_state;
    logic [FRM_W-1:0]       r_frm_cnt;
    logic [ARM_W-1:0]       r_arm_cnt;
    logic                   r_armed;
    speed_t                 r_tgt     [NUM_MOTORS];
    speed_t                 r_cur     [NUM_MOTORS];
    logic [NUM_MOTORS-1:0]  r_wrt;
    speed_t                 r_speed;
    logic                   r_busy;

    logic                   w_tick;
    logic                   w_exit;
    speed_t                 w_slew    [NUM_MOTORS];
    speed_t                 w_cur_nxt [NUM_MOTORS];
    logic [NUM_MOTORS-1:0]  w_ph_nxt;
    speed_t                 w_spd_nxt;

    assign w_tick = (r_frm_cnt == FRM_LAST);
    assign w_exit = (r_state != DISARMED) && (bus.kill || !bus.arm_req);

    for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_slew
        esc_slew_step #(.MAX_STEP(MAX_STEP)) u_slew (
            .i_cur (r_cur[g]),
            .i_tgt (r_tgt[g]),
            .o_nxt (w_slew[g])
        );
    end

    // Next current speeds; exits clear them in the same cycle so in-flight strobes carry 0.
    always_comb begin
        for (int i = 0; i < NUM_MOTORS; i++) begin
            w_cur_nxt[i] = r_cur[i];
            if ((r_state == DISARMED) || w_exit) begin
                w_cur_nxt[i] = '0;
            end else if ((r_state == RUN) && w_tick) begin
                w_cur_nxt[i] = w_slew[i];
            end
        end
    end

    // Next strobe position and the speed that travels with it.
    always_comb begin
        w_ph_nxt  = w_tick ? NUM_MOTORS'(1) : {r_wrt[NUM_MOTORS-2:0], 1'b0};
        w_spd_nxt = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            if (w_ph_nxt[i]) begin
                w_spd_nxt = w_cur_nxt[i];
            end
        end
    end

    // Free-running frame counter, targets, speeds and registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frm_cnt <= '0;
            r_tgt     <= '{default: '0};
            r_cur     <= '{default: '0};
            r_wrt     <= '0;
            r_speed   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_frm_cnt <= w_tick ? '0 : r_frm_cnt + 1'b1;
            r_cur     <= w_cur_nxt;
            r_wrt     <= w_ph_nxt;
            r_speed   <= w_spd_nxt;
            r_busy    <= |w_ph_nxt;
            if (bus.upd) begin
                r_tgt[0] <= bus.frnt_spd;
                r_tgt[1] <= bus.bck_spd;
                r_tgt[2] <= bus.lft_spd;
                r_tgt[3] <= bus.rght_spd;
            end
        end
    end

    // Arming FSM; exits take priority over any tick in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DISARMED;
            r_arm_cnt <= '0;
            r_armed   <= 1'b0;
        end else begin
            case (r_state)
                DISARMED: begin
                    if (w_tick && bus.arm_req && !bus.kill) begin
                        r_state   <= ARMING;
                        r_arm_cnt <= '0;
                    end
                end
                ARMING: begin
                    if (w_exit) begin
                        r_state <= DISARMED;
                    end else if (w_tick) begin
                        if (r_arm_cnt == ARM_LAST) begin
                            r_state <= RUN;
                            r_armed <= 1'b1;
                        end else begin
                            r_arm_cnt <= r_arm_cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (w_exit) begin
                        r_state <= DISARMED;
                        r_armed <= 1'b0;
                    end
                end
                default: begin
                    r_state <= DISARMED;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

    assign bus.SPEED = r_speed;
    assign bus.wrt   = r_wrt;
    assign bus.armed = r_armed;
    assign bus.busy  = r_busy;

endmodule
